// File: rtl/music_sequencer_poly.sv
// Multi-voice pattern sequencer: CHANNELS square-wave voices stepping through a
// writable half-period table every STEP_MS milliseconds, XOR-mixed onto one pin.
module music_sequencer_poly #(
  parameter int CHANNELS  = 2,
  parameter int DEPTH     = 16,
  parameter int DIV_WIDTH = 16,
  parameter int STEP_MS   = 250,
  parameter int TPM_WIDTH = 8,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int STEP_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TPM_WIDTH-1:0] ticks_per_milli,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop,
  input  logic                 wr_en,
  input  logic [CH_W-1:0]      wr_chan,
  input  logic [STEP_W-1:0]    wr_addr,
  input  logic [DIV_WIDTH-1:0] wr_data,
  output logic                 sound,
  output logic [CHANNELS-1:0]  voice,
  output logic                 busy,
  output logic [STEP_W-1:0]    step,
  output logic                 step_strobe,
  output logic [7:0]           led
);

  localparam int MS_W = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;
  localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(STEP_MS - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DEPTH - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t                state;
  state_t                state_n;

  logic [TPM_WIDTH-1:0]  presc;
  logic [TPM_WIDTH-1:0]  presc_n;
  logic [TPM_WIDTH-1:0]  presc_lim;
  logic [MS_W-1:0]       ms_cnt;
  logic [MS_W-1:0]       ms_n;
  logic [STEP_W-1:0]     step_n;
  logic [DIV_WIDTH-1:0]  mem      [CHANNELS][DEPTH];
  logic [DIV_WIDTH-1:0]  hp       [CHANNELS];
  logic [DIV_WIDTH-1:0]  tone_cnt [CHANNELS];
  logic [DIV_WIDTH-1:0]  tone_n   [CHANNELS];
  logic [CHANNELS-1:0]   voice_n;
  logic                  start_go;
  logic                  play_cont;
  logic                  ms_tick;
  logic                  step_end;
  logic                  last_step;
  logic                  strobe_n;
  logic                  busy_n;
  logic                  sound_n;
  logic [5:0]            step_ext;
  logic [7:0]            led_n;

  // A zero or one ticks_per_milli both collapse to a tick every cycle.
  assign presc_lim = (ticks_per_milli == '0) ? '0 : ticks_per_milli - 1'b1;
  assign start_go  = start & ~stop;
  assign play_cont = (state == PLAY) & ~stop & ~start;
  assign ms_tick   = (state == PLAY) && (presc >= presc_lim);
  assign step_end  = ms_tick && (ms_cnt >= MS_LAST);
  assign last_step = (step == STEP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int d = 0; d < DEPTH; d++)
          mem[c][d] <= '0;
    end else if (wr_en && (int'(wr_chan) < CHANNELS)) begin
      mem[wr_chan][wr_addr] <= wr_data;
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++)
      hp[c] = mem[c][step];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (stop)
      state_n = IDLE;
    else if (start_go)
      state_n = PLAY;
    else if ((state == PLAY) && step_end && last_step && !loop)
      state_n = IDLE;
  end

  // Anything other than an uninterrupted PLAY cycle leaves every counter and voice at zero.
  always_comb begin
    presc_n  = '0;
    ms_n     = '0;
    step_n   = '0;
    strobe_n = 1'b0;
    voice_n  = '0;
    for (int c = 0; c < CHANNELS; c++)
      tone_n[c] = '0;
    if (play_cont) begin
      presc_n = ms_tick ? '0 : presc + 1'b1;
      ms_n    = ms_cnt;
      if (ms_tick)
        ms_n = step_end ? '0 : ms_cnt + 1'b1;
      if (step_end) begin
        strobe_n = 1'b1;
        step_n   = last_step ? '0 : step + 1'b1;
      end else begin
        step_n = step;
        for (int c = 0; c < CHANNELS; c++) begin
          if (hp[c] == '0) begin
            voice_n[c] = 1'b0;
            tone_n[c]  = '0;
          end else if (tone_cnt[c] >= hp[c] - 1'b1) begin
            voice_n[c] = ~voice[c];
            tone_n[c]  = '0;
          end else begin
            voice_n[c] = voice[c];
            tone_n[c]  = tone_cnt[c] + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    busy_n                 = (state_n == PLAY);
    sound_n                = ^voice_n;
    step_ext               = '0;
    step_ext[STEP_W-1:0]   = step_n;
    led_n                  = {busy_n, sound_n, step_ext};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc       <= '0;
      ms_cnt      <= '0;
      step        <= '0;
      voice       <= '0;
      step_strobe <= 1'b0;
      busy        <= 1'b0;
      sound       <= 1'b0;
      led         <= '0;
      for (int c = 0; c < CHANNELS; c++)
        tone_cnt[c] <= '0;
    end else begin
      presc       <= presc_n;
      ms_cnt      <= ms_n;
      step        <= step_n;
      voice       <= voice_n;
      step_strobe <= strobe_n;
      busy        <= busy_n;
      sound       <= sound_n;
      led         <= led_n;
      for (int c = 0; c < CHANNELS; c++)
        tone_cnt[c] <= tone_n[c];
    end
  end

endmodule

// File: tb/tb_music_sequencer_poly.sv
// Directed bench for music_sequencer_poly with CHANNELS=2, DEPTH=4, STEP_MS=2;
// at tpm=3 one step lasts 6 clocks.
module tb_music_sequencer_poly;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tpm;
  logic        start;
  logic        stop;
  logic        loop;
  logic        wr_en;
  logic [0:0]  wr_chan;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        sound;
  logic [1:0]  voice;
  logic        busy;
  logic [1:0]  step;
  logic        step_strobe;
  logic [7:0]  led;

  int n_cmp  = 0;
  int n_fail = 0;

  // voice[0] after edge N+k for pattern ch0 = {1,2,3,0}
  int exp_v0 [25] = '{0,1,0,1,0,1, 0,0,1,1,0,0, 0,0,0,1,1,1, 0,0,0,0,0,0, 0};

  music_sequencer_poly #(
    .CHANNELS(2), .DEPTH(4), .DIV_WIDTH(16), .STEP_MS(2), .TPM_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .ticks_per_milli(tpm),
    .start(start), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_chan(wr_chan), .wr_addr(wr_addr), .wr_data(wr_data),
    .sound(sound), .voice(voice), .busy(busy), .step(step),
    .step_strobe(step_strobe), .led(led)
  );

  always #5 clk = ~clk;

  task automatic step_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input int ch, input int addr, input int data);
    wr_en   = 1'b1;
    wr_chan = 1'(ch);
    wr_addr = 2'(addr);
    wr_data = 16'(data);
    step_clk;
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step_clk;
    start = 1'b0;
  endtask

  task automatic pulse_stop;
    stop = 1'b1;
    step_clk;
    stop = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({busy, sound, voice, step, step_strobe} !== 7'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b expected 0", {busy, sound, voice, step, step_strobe});
    end
    n_cmp++;
    if (led !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_led: got %h expected 00", led);
    end
    rst = 1'b0;
    step_clk;
    for (int a = 0; a < 4; a++) write_mem(0, a, 1);
    pulse_start;
    repeat (8) step_clk;
    n_cmp++;
    if (busy !== 1'b1 || step !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_play: got busy=%b step=%0d expected busy=1 step=1", busy, step);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, sound, voice, step, step_strobe} !== 7'd0) begin
      n_fail++;
      $display("[TB] FAIL midplay_reset: got %b expected 0", {busy, sound, voice, step, step_strobe});
    end
    n_cmp++;
    if (led !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL midplay_reset_led: got %h expected 00", led);
    end
    #1 rst = 1'b0;
    step_clk;
    pulse_start;
    for (int k = 1; k <= 24; k++) begin
      step_clk;
      n_cmp++;
      if (voice !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL mem_cleared k=%0d: got voice=%b expected 00", k, voice);
      end
      n_cmp++;
      if (busy !== (k < 24)) begin
        n_fail++;
        $display("[TB] FAIL mem_cleared_busy k=%0d: got %b expected %b", k, busy, (k < 24));
      end
    end
  endtask

  task automatic test_basic;
    int es;
    logic eb, est;
    write_mem(0, 0, 1);
    write_mem(0, 1, 2);
    write_mem(0, 2, 3);
    write_mem(0, 3, 0);
    loop = 1'b0;
    pulse_start;
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) step_clk;
      es  = (k < 24) ? k / 6 : 0;
      eb  = (k < 24);
      est = (k > 0) && (k % 6 == 0);
      n_cmp++;
      if (voice !== {1'b0, 1'(exp_v0[k])} || sound !== 1'(exp_v0[k])) begin
        n_fail++;
        $display("[TB] FAIL basic_voice k=%0d: got voice=%b sound=%b expected voice0=%0d", k, voice, sound, exp_v0[k]);
      end
      n_cmp++;
      if (step !== 2'(es) || busy !== eb || step_strobe !== est) begin
        n_fail++;
        $display("[TB] FAIL basic_seq k=%0d: got step=%0d busy=%b strobe=%b expected %0d %b %b",
                 k, step, busy, step_strobe, es, eb, est);
      end
    end
  endtask

  task automatic test_loop;
    int es;
    logic est;
    loop = 1'b1;
    pulse_start;
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) step_clk;
      es  = (k / 6) % 4;
      est = (k > 0) && (k % 6 == 0);
      n_cmp++;
      if (step !== 2'(es) || busy !== 1'b1 || step_strobe !== est) begin
        n_fail++;
        $display("[TB] FAIL loop_seq k=%0d: got step=%0d busy=%b strobe=%b expected %0d 1 %b",
                 k, step, busy, step_strobe, es, est);
      end
      if (k == 25) begin
        n_cmp++;
        if (voice[0] !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL loop_rewrap_voice: got %b expected 1", voice[0]);
        end
      end
    end
    pulse_stop;
    loop = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || step !== 2'd0 || voice !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL loop_stop: got busy=%b step=%0d voice=%b expected 0 0 00", busy, step, voice);
    end
  endtask

  task automatic test_mix;
    logic v0, v1;
    int es;
    write_mem(0, 0, 2);
    write_mem(1, 0, 3);
    pulse_start;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) step_clk;
      v0 = (k < 6) ? 1'((k / 2) & 1) : 1'b0;
      v1 = (k < 6) ? 1'((k / 3) & 1) : 1'b0;
      es = k / 6;
      n_cmp++;
      if (voice !== {v1, v0} || sound !== (v0 ^ v1)) begin
        n_fail++;
        $display("[TB] FAIL mix_voice k=%0d: got voice=%b sound=%b expected %b%b %b", k, voice, sound, v1, v0, v0 ^ v1);
      end
      n_cmp++;
      if (led !== {1'b1, v0 ^ v1, 4'b0000, 2'(es)}) begin
        n_fail++;
        $display("[TB] FAIL mix_led k=%0d: got %b expected %b", k, led, {1'b1, v0 ^ v1, 4'b0000, 2'(es)});
      end
    end
    pulse_stop;
  endtask

  task automatic test_conflict;
    start = 1'b1;
    stop  = 1'b1;
    step_clk;
    start = 1'b0;
    stop  = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || led !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL conflict_idle: got busy=%b led=%h expected 0 00", busy, led);
    end
    pulse_start;
    repeat (3) step_clk;
    start = 1'b1;
    stop  = 1'b1;
    step_clk;
    start = 1'b0;
    stop  = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || step !== 2'd0 || voice !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL conflict_play: got busy=%b step=%0d voice=%b expected 0 0 00", busy, step, voice);
    end
    pulse_start;
    repeat (14) step_clk;
    n_cmp++;
    if (step !== 2'd2) begin
      n_fail++;
      $display("[TB] FAIL restart_pre: got step=%0d expected 2", step);
    end
    pulse_start;
    n_cmp++;
    if (step !== 2'd0 || busy !== 1'b1 || voice !== 2'b00 || step_strobe !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL restart_edge: got step=%0d busy=%b voice=%b strobe=%b expected 0 1 00 0",
               step, busy, voice, step_strobe);
    end
    repeat (2) step_clk;
    n_cmp++;
    if (voice !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL restart_voice: got %b expected 01", voice);
    end
    repeat (3) step_clk;
    n_cmp++;
    if (step !== 2'd0 || step_strobe !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL restart_n5: got step=%0d strobe=%b expected 0 0", step, step_strobe);
    end
    step_clk;
    n_cmp++;
    if (step !== 2'd1 || step_strobe !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL restart_n6: got step=%0d strobe=%b expected 1 1", step, step_strobe);
    end
    pulse_stop;
  endtask

  task automatic test_live_write;
    logic ev;
    tpm = 8'd10;
    write_mem(0, 0, 5);
    write_mem(1, 0, 0);
    pulse_start;
    repeat (3) step_clk;
    wr_en   = 1'b1;
    wr_chan = 1'b0;
    wr_addr = 2'd0;
    wr_data = 16'd2;
    step_clk;
    wr_en   = 1'b0;
    n_cmp++;
    if (voice !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL live_n4: got %b expected 00", voice);
    end
    for (int k = 5; k <= 9; k++) begin
      step_clk;
      ev = (k == 5) || (k == 6) || (k == 9);
      n_cmp++;
      if (voice !== {1'b0, ev}) begin
        n_fail++;
        $display("[TB] FAIL live_write k=%0d: got %b expected 0%b", k, voice, ev);
      end
    end
    n_cmp++;
    if (step !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL live_step: got %0d expected 0", step);
    end
    pulse_stop;
    tpm = 8'd0;
    pulse_start;
    step_clk;
    n_cmp++;
    if (step !== 2'd0 || step_strobe !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL tpm0_n1: got step=%0d strobe=%b expected 0 0", step, step_strobe);
    end
    step_clk;
    n_cmp++;
    if (step !== 2'd1 || step_strobe !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL tpm0_n2: got step=%0d strobe=%b expected 1 1", step, step_strobe);
    end
    repeat (2) step_clk;
    n_cmp++;
    if (step !== 2'd2 || step_strobe !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL tpm0_n4: got step=%0d strobe=%b expected 2 1", step, step_strobe);
    end
    pulse_stop;
    tpm = 8'd3;
  endtask

  initial begin
    rst     = 1'b1;
    tpm     = 8'd3;
    start   = 1'b0;
    stop    = 1'b0;
    loop    = 1'b0;
    wr_en   = 1'b0;
    wr_chan = '0;
    wr_addr = '0;
    wr_data = '0;
    repeat (2) step_clk;
    test_reset;
    test_basic;
    test_loop;
    test_mix;
    test_conflict;
    test_live_write;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/music_sequencer_poly.md
# music_sequencer_poly

Parametrised multi-voice successor to the single-voice music processor. Plays a writable pattern memory of CHANNELS × DEPTH square-wave half-period values, advancing one step every STEP_MS milliseconds, with one-shot or loop playback. Voices are XOR-mixed onto the speaker pin; the LED bus shows status and step. Sits under the top-level wrapper in place of the single-voice processor: sound drives uio_out[0], led drives uo_out.

## Interface
- CHANNELS, 2: number of independent voices (1..8)
- DEPTH, 16: pattern steps per channel (2..64, power of two)
- DIV_WIDTH, 16: half-period width in clk cycles
- STEP_MS, 250: step duration in milliseconds (≥1)
- TPM_WIDTH, 8: width of ticks_per_milli

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ticks_per_milli  in  TPM_WIDTH  clk cycles per millisecond
- start  in  1  pulse: begin playback at step 0
- stop  in  1  pulse: halt playback
- loop  in  1  1 = wrap after step DEPTH-1; sampled at end of last step
- wr_en  in  1  pattern write strobe
- wr_chan  in  max(1,clog2(CHANNELS))  write channel; values ≥ CHANNELS are ignored
- wr_addr  in  clog2(DEPTH)  write step
- wr_data  in  DIV_WIDTH  half-period; 0 = rest
- sound  out  1  XOR of all voices
- voice  out  CHANNELS  per-channel square waves
- busy  out  1  1 in PLAY
- step  out  clog2(DEPTH)  current step index
- step_strobe  out  1  one-cycle pulse on each step advance or end
- led  out  8  {busy, sound, step zero-extended to 6 bits}

## Operation
- States: IDLE, PLAY.
- IDLE: prescaler, ms counter, tone counters held at 0; voice=0, step=0, busy=0.
- IDLE/PLAY + start (stop low): enter or restart PLAY with step=0 and all counters and voices cleared.
- stop: go to IDLE; stop wins over start in the same cycle.
- Prescaler: counts 0..tpm-1 and pulses ms_tick on the wrap. ticks_per_milli 0 or 1 produces ms_tick every cycle.
- ms counter: counts ms_ticks. On the STEP_MS-th tick:
  - If step<DEPTH-1: step+1.
  - Else if loop=1: step wraps to 0.
  - Else: go to IDLE.
  - In all three cases, step_strobe=1 and the ms counter returns to 0.
- Tone generator per channel, with hp = mem[ch][step]:
  - hp=0: voice forced to 0 and counter held at 0.
  - Otherwise, each PLAY cycle: if counter ≥ hp-1, toggle voice and set counter to 0; else counter+1.
  - Output frequency = f_clk/(2·hp).
  - On every step change, counter and voice are cleared.
- Pattern memory:
  - Writable in any state; one entry per cycle.
  - Reset clears all entries to 0 (rest).
  - A write to the entry currently playing affects the compare from the next cycle. Counter is not reset; the ≥ compare prevents a runaway.
- ticks_per_milli may change at any time. The prescaler uses the same ≥ compare, giving no runaway.

## Timing
- Reset (async): all outputs 0, state IDLE, memory 0.
- All outputs are registered.
- Start at clock edge N: from edge N, busy=1, step=0, voice=0.
- With t = max(tpm,1), step k begins at edge N + k·t·STEP_MS. step_strobe is high for the cycle after that edge.
- First toggle of a voice with hp=h occurs at edge N+h. Subsequent toggles are every h cycles.
- One-shot end: busy falls at edge N + DEPTH·t·STEP_MS, together with step_strobe.
- A write at edge M is visible to playback from edge M+1.
- Reset asserted mid-play: immediate IDLE, memory cleared.

## Test plan
Configuration for all cases: CHANNELS=2, DEPTH=4, STEP_MS=2, tpm=3, so one step = 6 cycles.

- **Reset:** assert rst mid-PLAY → busy, voice, sound, led, step = 0 immediately, and mem reads back as rests.
- **Basic playback:** write ch0 hp={1,2,3,0}, ch1 all 0, pulse start at edge N.
  - voice[0] toggles every cycle through edge N+5, then every 2 cycles, then every 3.
  - voice[0]=0 for step 3.
  - busy falls at N+24 with step_strobe.
- **Loop:** loop=1 → step sequence 0,1,2,3,0 with step_strobe at N+6, 12, 18, 24; busy stays 1.
- **Two-voice mix:** ch0 hp=2, ch1 hp=3 → sound = voice[0]^voice[1] every cycle; led[6]=sound, led[5:0]=step.
- **start/stop conflicts:**
  - start and stop in the same cycle → IDLE.
  - start mid-step 2 → step=0 and counters restart from that edge.
- **Live write:** while step 0 plays hp=5 with counter at 3, write hp=2 → toggle on the next cycle (counter 4 ≥ 1), then every 2 cycles. tpm=0 → step advances every STEP_MS cycles.
